// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: EX->MEM register, load extraction, and a wait-state FSM for a variable-latency data SRAM.
// Optional MEM_WAIT_CNT_EN adds a saturating wait_cycles counter output.
module mem_stage_ws #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = 6,
  parameter int MEM_BIT = 3,
  parameter int WB_BIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic [31:0]               in_pc,
  input  logic                      in_ram_en,
  input  logic [3:0]                in_ram_wen,
  input  logic [2:0]                in_load_op,
  input  logic                      in_sel_rf_res,
  input  logic                      in_rf_we,
  input  logic [RF_AW-1:0]          in_rf_waddr,
  input  logic [DATA_W-1:0]         in_ex_result,
  input  logic [DATA_W-1:0]         data_sram_rdata,
  input  logic                      data_ok,
  output logic                      stallreq_mem,
  output logic [31:0]               wb_pc,
  output logic                      wb_rf_we,
  output logic [RF_AW-1:0]          wb_rf_waddr,
  output logic [DATA_W-1:0]         wb_rf_wdata,
  output logic [1+RF_AW+DATA_W-1:0] fwd_bus
`ifdef MEM_WAIT_CNT_EN
  , output logic [31:0]             wait_cycles
`endif
);

  typedef struct packed {
    logic [31:0]       pc;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [2:0]        load_op;
    logic              sel_rf_res;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] ex_result;
  } mem_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  mem_req_t          r, in_req;
  state_t            state, state_nxt;
  logic [DATA_W-1:0] hold_q, ext, load_data;
  logic              bubble, advance, next_is_load, is_load, waiting;
  logic [1:0]        a;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign in_req = '{pc: in_pc, ram_en: in_ram_en, ram_wen: in_ram_wen, load_op: in_load_op,
                    sel_rf_res: in_sel_rf_res, rf_we: in_rf_we, rf_waddr: in_rf_waddr,
                    ex_result: in_ex_result};

  assign bubble  = stall[MEM_BIT] & ~stall[WB_BIT];
  assign advance = ~stall[MEM_BIT] | bubble;
  // A bubble never carries a load, so only a real input load can start a wait.
  assign next_is_load = ~stall[MEM_BIT] & in_ram_en & in_sel_rf_res & (in_ram_wen == 4'd0);
  assign is_load      = r.ram_en & r.sel_rf_res & (r.ram_wen == 4'd0);

  always_ff @(posedge clk) begin
    if (rst)                  r <= '0;
    else if (bubble)          r <= '0;
    else if (~stall[MEM_BIT]) r <= in_req;
  end

  always_comb begin
    state_nxt = state;
    if (advance)                     state_nxt = next_is_load ? WAIT : IDLE;
    else if (state == WAIT && data_ok) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && !advance && data_ok) hold_q <= ext;
    end
  end

  assign a      = r.ex_result[1:0];
  assign byte_v = data_sram_rdata[{a, 3'b000} +: 8];
  assign half_v = a[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

  always_comb begin
    case (r.load_op)
      3'd1:    ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'd2:    ext = {{(DATA_W-8){1'b0}}, byte_v};
      3'd3:    ext = {{(DATA_W-16){half_v[15]}}, half_v};
      3'd4:    ext = {{(DATA_W-16){1'b0}}, half_v};
      default: ext = data_sram_rdata;
    endcase
  end

  assign load_data = (state == DONE) ? hold_q : ext;
  // Outputs are forced low while rst is high so nothing stale leaks before the reset edge.
  assign waiting      = (state == WAIT) & ~data_ok;
  assign stallreq_mem = ~rst & waiting;
  assign wb_pc        = rst ? '0 : r.pc;
  assign wb_rf_we     = ~rst & r.rf_we & ~waiting;
  assign wb_rf_waddr  = rst ? '0 : r.rf_waddr;
  assign wb_rf_wdata  = rst ? '0 : (is_load ? load_data : r.ex_result);
  assign fwd_bus      = {wb_rf_we, wb_rf_waddr, wb_rf_wdata};

`ifdef MEM_WAIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                   wait_cycles <= '0;
    else if (stallreq_mem && wait_cycles != '1) wait_cycles <= wait_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed self-checking bench for mem_stage_ws: ALU pass-through, load waits, extraction, hold, bubble, reset.
module tb_mem_stage_ws;
  logic        clk, rst;
  logic [5:0]  stall;
  logic [31:0] in_pc, in_ex_result, data_sram_rdata;
  logic        in_ram_en, in_sel_rf_res, in_rf_we, data_ok;
  logic [3:0]  in_ram_wen;
  logic [2:0]  in_load_op;
  logic [4:0]  in_rf_waddr;
  logic        stallreq_mem, wb_rf_we;
  logic [31:0] wb_pc, wb_rf_wdata;
  logic [4:0]  wb_rf_waddr;
  logic [37:0] fwd_bus;
`ifdef MEM_WAIT_CNT_EN
  logic [31:0] wait_cycles;
`endif
  int pass_cnt = 0, total = 0;

  mem_stage_ws dut (
    .clk(clk), .rst(rst), .stall(stall), .in_pc(in_pc), .in_ram_en(in_ram_en),
    .in_ram_wen(in_ram_wen), .in_load_op(in_load_op), .in_sel_rf_res(in_sel_rf_res),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result),
    .data_sram_rdata(data_sram_rdata), .data_ok(data_ok), .stallreq_mem(stallreq_mem),
    .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .fwd_bus(fwd_bus)
`ifdef MEM_WAIT_CNT_EN
    , .wait_cycles(wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic nop();
    in_pc = '0; in_ram_en = 0; in_ram_wen = '0; in_load_op = '0;
    in_sel_rf_res = 0; in_rf_we = 0; in_rf_waddr = '0; in_ex_result = '0;
  endtask

  task automatic issue_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] wa);
    in_pc = 32'h400; in_ram_en = 1; in_ram_wen = '0; in_load_op = op;
    in_sel_rf_res = 1; in_rf_we = 1; in_rf_waddr = wa; in_ex_result = addr;
  endtask

  task automatic test_reset();
    rst = 1; stall = '0; data_ok = 0; data_sram_rdata = '0; nop();
    step(); step();
    total++; if (fwd_bus !== '0 || stallreq_mem !== 1'b0 || wb_pc !== '0) begin
      $display("FAIL reset_during got fwd=%h stallreq=%b pc=%h exp all 0", fwd_bus, stallreq_mem, wb_pc);
    end else pass_cnt++;
    rst = 0; step(); #1;
    total++; if (fwd_bus !== '0 || stallreq_mem !== 1'b0 || wb_pc !== '0) begin
      $display("FAIL reset_after got fwd=%h stallreq=%b pc=%h exp all 0", fwd_bus, stallreq_mem, wb_pc);
    end else pass_cnt++;
  endtask

  task automatic test_alu();
    nop(); in_pc = 32'h100; in_ex_result = 32'h1234; in_rf_we = 1; in_rf_waddr = 5'd5;
    step(); nop(); #1;
    total++; if (wb_rf_we !== 1'b1 || wb_rf_waddr !== 5'd5 || wb_rf_wdata !== 32'h1234 || stallreq_mem !== 1'b0) begin
      $display("FAIL alu got we=%b wa=%0d wd=%h sr=%b exp 1 5 00001234 0", wb_rf_we, wb_rf_waddr, wb_rf_wdata, stallreq_mem);
    end else pass_cnt++;
    total++; if (fwd_bus !== {1'b1, 5'd5, 32'h1234} || wb_pc !== 32'h100) begin
      $display("FAIL alu_fwd got fwd=%h pc=%h exp %h 00000100", fwd_bus, wb_pc, {1'b1, 5'd5, 32'h1234});
    end else pass_cnt++;
  endtask

  task automatic test_lb_wait();
    issue_load(3'd1, 32'h1003, 5'd7);
    step(); nop(); stall = 6'h1F; data_ok = 0; data_sram_rdata = 32'h80FF_0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (stallreq_mem !== 1'b1 || wb_rf_we !== 1'b0 || fwd_bus[37] !== 1'b0) begin
        $display("FAIL lb_wait%0d got sr=%b we=%b exp 1 0", c, stallreq_mem, wb_rf_we);
      end else pass_cnt++;
      step();
    end
    data_ok = 1; stall = '0; #1;
    total++; if (stallreq_mem !== 1'b0 || wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'hFFFF_FF80 || wb_rf_waddr !== 5'd7) begin
      $display("FAIL lb_data got sr=%b we=%b wd=%h exp 0 1 ffffff80", stallreq_mem, wb_rf_we, wb_rf_wdata);
    end else pass_cnt++;
  endtask

  task automatic test_lhu_zero_wait();
    issue_load(3'd4, 32'h2002, 5'd9);
    step(); nop(); stall = '0; data_ok = 1; data_sram_rdata = 32'hBEEF_1234; #1;
    total++; if (stallreq_mem !== 1'b0 || wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'h0000_BEEF) begin
      $display("FAIL lhu got sr=%b we=%b wd=%h exp 0 1 0000beef", stallreq_mem, wb_rf_we, wb_rf_wdata);
    end else pass_cnt++;
  endtask

  task automatic test_lw_hold();
    issue_load(3'd0, 32'h3000, 5'd3);
    step(); nop(); stall = 6'h1F; data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; #1;
    total++; if (wb_rf_wdata !== 32'hCAFE_F00D || stallreq_mem !== 1'b0) begin
      $display("FAIL lw_first got wd=%h sr=%b exp cafef00d 0", wb_rf_wdata, stallreq_mem);
    end else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step(); data_ok = 0; data_sram_rdata = 32'hDEAD_BEEF; #1;
      total++; if (wb_rf_wdata !== 32'hCAFE_F00D || stallreq_mem !== 1'b0 || wb_rf_we !== 1'b1) begin
        $display("FAIL lw_hold%0d got wd=%h sr=%b we=%b exp cafef00d 0 1", c, wb_rf_wdata, stallreq_mem, wb_rf_we);
      end else pass_cnt++;
    end
    stall = '0;
  endtask

  localparam logic [2:0]  X_OP [6] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd6, 3'd1};
  localparam logic [31:0] X_AD [6] = '{32'h1, 32'h0, 32'h3, 32'h0, 32'h2, 32'h2};
  localparam logic [31:0] X_RD [6] = '{32'h1234_8756, 32'h0000_007F, 32'h8001_FFFF,
                                       32'h0000_7FFF, 32'hA5A5_5A5A, 32'h0080_0000};
  localparam logic [31:0] X_EX [6] = '{32'h0000_0087, 32'h0000_007F, 32'hFFFF_8001,
                                       32'h0000_7FFF, 32'hA5A5_5A5A, 32'hFFFF_FF80};

  task automatic test_extract();
    for (int i = 0; i < 6; i++) begin
      issue_load(X_OP[i], X_AD[i], 5'd1);
      step(); nop(); stall = '0; data_ok = 1; data_sram_rdata = X_RD[i]; #1;
      total++; if (wb_rf_wdata !== X_EX[i] || stallreq_mem !== 1'b0) begin
        $display("FAIL extract%0d got wd=%h sr=%b exp %h 0", i, wb_rf_wdata, stallreq_mem, X_EX[i]);
      end else pass_cnt++;
    end
    data_ok = 0;
  endtask

  task automatic test_store();
    nop(); in_ram_en = 1; in_ram_wen = 4'hF; in_sel_rf_res = 1; in_ex_result = 32'h44;
    step(); nop(); stall = '0; data_ok = 0; data_sram_rdata = 32'h9999_9999; #1;
    total++; if (stallreq_mem !== 1'b0 || wb_rf_wdata !== 32'h44 || wb_rf_we !== 1'b0) begin
      $display("FAIL store got sr=%b wd=%h we=%b exp 0 00000044 0", stallreq_mem, wb_rf_wdata, wb_rf_we);
    end else pass_cnt++;
  endtask

  task automatic test_bubble();
    nop(); in_pc = 32'h200; in_ex_result = 32'h55; in_rf_we = 1; in_rf_waddr = 5'd4;
    step(); stall = 6'b001000; #1;
    total++; if (wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'h55) begin
      $display("FAIL bubble_pre got we=%b wd=%h exp 1 00000055", wb_rf_we, wb_rf_wdata);
    end else pass_cnt++;
    step(); stall = '0; nop(); #1;
    total++; if (wb_pc !== '0 || fwd_bus !== '0 || stallreq_mem !== 1'b0) begin
      $display("FAIL bubble got pc=%h fwd=%h sr=%b exp all 0", wb_pc, fwd_bus, stallreq_mem);
    end else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    issue_load(3'd0, 32'h5000, 5'd6);
    step(); nop(); stall = 6'h1F; data_ok = 0; #1;
    total++; if (stallreq_mem !== 1'b1) begin
      $display("FAIL rstwait_pre got sr=%b exp 1", stallreq_mem);
    end else pass_cnt++;
    rst = 1; step(); rst = 0; data_ok = 1; data_sram_rdata = 32'h1111_1111; #1;
    total++; if (stallreq_mem !== 1'b0 || fwd_bus !== '0 || wb_pc !== '0) begin
      $display("FAIL rstwait got sr=%b fwd=%h pc=%h exp all 0", stallreq_mem, fwd_bus, wb_pc);
    end else pass_cnt++;
    step(); data_ok = 0; stall = '0; #1;
    total++; if (fwd_bus !== '0 || stallreq_mem !== 1'b0) begin
      $display("FAIL rstwait_late got fwd=%h sr=%b exp 0 0", fwd_bus, stallreq_mem);
    end else pass_cnt++;
  endtask

`ifdef MEM_WAIT_CNT_EN
  task automatic test_wait_cnt();
    rst = 1; step(); rst = 0; #1;
    total++; if (wait_cycles !== 32'd0) begin
      $display("FAIL waitcnt_reset got %0d exp 0", wait_cycles);
    end else pass_cnt++;
    for (int k = 2; k <= 3; k++) begin
      issue_load(3'd0, 32'h6000, 5'd2);
      step(); nop(); stall = 6'h1F; data_ok = 0;
      repeat (k) step();
      data_ok = 1; stall = '0;
      step(); data_ok = 0;
    end
    #1;
    total++; if (wait_cycles !== 32'd5) begin
      $display("FAIL waitcnt got %0d exp 5", wait_cycles);
    end else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_lb_wait();
    test_lhu_zero_wait();
    test_lw_hold();
    test_extract();
    test_store();
    test_bubble();
    test_reset_in_wait();
`ifdef MEM_WAIT_CNT_EN
    test_wait_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
